// File: rtl/mux_loader_pkg.sv
// Shared types and constants for the mux operand loader.
// Build option: MUX_OPERAND_SWAP_EN adds a fourth key that swaps x and y.
package mux_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_X = 2'd1,
    HAVE_Y = 2'd2,
    READY  = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  localparam int KEY_LOAD_X   = 0;
  localparam int KEY_LOAD_Y   = 1;
  localparam int KEY_TOGGLE_S = 2;
  localparam int KEY_SWAP     = 3;

`ifdef MUX_OPERAND_SWAP_EN
  localparam int KEY_W = 4;
`else
  localparam int KEY_W = 3;
`endif

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchronizer, counter debounce and a one-cycle
// press pulse on each debounced release-to-press transition.
module key_debounce
  import mux_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n_raw,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             level, level_q;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A key held through reset must be seen released before it may fire,
  // so presses are only reported once a released level has been observed.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      level_q     <= 1'b1;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      level_q     <= level;
      armed       <= armed | (sync2 & level);
      press_pulse <= armed & level_q & ~level;
    end
  end

endmodule

// File: rtl/mux_operand_loader.sv
// Loads mux operands x/y from switches and toggles select s from debounced keys.
// Build option: MUX_OPERAND_SWAP_EN enables KEY[3] to swap x and y in READY.
module mux_operand_loader
  import mux_loader_pkg::*;
#(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N-1:0]     SW,
  input  logic [KEY_W-1:0] KEY,
  output logic [N-1:0]     x,
  output logic [N-1:0]     y,
  output logic             s,
  output logic             valid,
  output logic [1:0]       LEDG
);

  logic [1:0]       rst_pipe;
  logic             rst_int;
  logic [KEY_W-1:0] press;
  logic             press_x, press_y;
  state_t           state, next_state;

  // Reset asserts immediately but releases in step with the clock.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .CLOCK_50   (CLOCK_50),
      .reset      (rst_int),
      .key_n_raw  (KEY[i]),
      .press_pulse(press[i])
    );
  end

  assign press_x = press[KEY_LOAD_X];
  assign press_y = press[KEY_LOAD_Y];

  always_ff @(posedge CLOCK_50 or posedge rst_int) begin
    if (rst_int) state <= EMPTY;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (press_x && press_y) next_state = READY;
        else if (press_x)       next_state = HAVE_X;
        else if (press_y)       next_state = HAVE_Y;
      end
      HAVE_X:  if (press_y) next_state = READY;
      HAVE_Y:  if (press_x) next_state = READY;
      READY:   next_state = READY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    valid   = (state == READY);
    LEDG    = 2'b00;
    LEDG[0] = (state == HAVE_X) || (state == READY);
    LEDG[1] = (state == HAVE_Y) || (state == READY);
  end

`ifdef MUX_OPERAND_SWAP_EN
  // Loads take priority; a swap only happens on its own in READY.
  logic swap_go;
  assign swap_go = press[KEY_SWAP] && (state == READY) && !press_x && !press_y;
`endif

  always_ff @(posedge CLOCK_50 or posedge rst_int) begin
    if (rst_int) begin
      x <= '0;
      y <= '0;
    end else begin
      if (press_x) x <= SW;
`ifdef MUX_OPERAND_SWAP_EN
      else if (swap_go) x <= y;
`endif
      if (press_y) y <= SW;
`ifdef MUX_OPERAND_SWAP_EN
      else if (swap_go) y <= x;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst_int) begin
    if (rst_int)                    s <= 1'b0;
    else if (press[KEY_TOGGLE_S])   s <= ~s;
  end

endmodule
